// File: rtl/linear_proj_pkg.sv
// rtl/linear_proj_pkg.sv - shared linear-projection geometry and loader state type
package linear_proj_pkg;

    localparam int WIDTH_A           = 8;
    localparam int CHUNK_SIZE        = 4;
    localparam int NUM_CORES_A       = 1;
    localparam int NUM_A_ELEMENTS    = 8;
    localparam int INNER_DIMENSION   = 8;
    localparam int A_OUTER_DIMENSION = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_t;

endpackage

// File: rtl/in_mat_stream_loader.sv
// rtl/in_mat_stream_loader.sv - streams input-matrix words into a dual-port BRAM, two words per write cycle
module in_mat_stream_loader
    import linear_proj_pkg::*;
#(
    parameter int DATA_WIDTH_A = WIDTH_A * CHUNK_SIZE * NUM_CORES_A,
    parameter int NUM_ELEMS    = NUM_A_ELEMENTS,
    parameter int ADDR_WIDTH_A = $clog2(INNER_DIMENSION * A_OUTER_DIMENSION * WIDTH_A / DATA_WIDTH_A)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [DATA_WIDTH_A-1:0] s_tdata,
    input  logic                    s_tlast,
    output logic                    in_mat_ena,
    output logic                    in_mat_wea,
    output logic [ADDR_WIDTH_A-1:0] in_mat_wr_addra,
    output logic [DATA_WIDTH_A-1:0] in_mat_dina,
    output logic                    in_mat_enb,
    output logic                    in_mat_web,
    output logic [ADDR_WIDTH_A-1:0] in_mat_wr_addrb,
    output logic [DATA_WIDTH_A-1:0] in_mat_dinb,
    output logic                    load_done,
    output logic                    err_len
);

    localparam logic [ADDR_WIDTH_A-1:0] LAST_IDX = ADDR_WIDTH_A'(NUM_ELEMS - 1);
    localparam logic [ADDR_WIDTH_A-1:0] ONE      = ADDR_WIDTH_A'(1);

    load_state_t             state;
    logic [ADDR_WIDTH_A-1:0] idx;
    logic [DATA_WIDTH_A-1:0] hold;
    logic                    finishing;

    logic accept;
    logic at_last;
    logic final_beat;

    always_comb begin
        accept     = s_tvalid && s_tready;
        at_last    = (idx == LAST_IDX);
        final_beat = at_last || s_tlast;
    end

    // finishing marks the write cycle of the last beat; load_done follows one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            idx             <= '0;
            hold            <= '0;
            finishing       <= 1'b0;
            s_tready        <= 1'b0;
            in_mat_ena      <= 1'b0;
            in_mat_wea      <= 1'b0;
            in_mat_enb      <= 1'b0;
            in_mat_web      <= 1'b0;
            in_mat_wr_addra <= '0;
            in_mat_wr_addrb <= '0;
            in_mat_dina     <= '0;
            in_mat_dinb     <= '0;
            load_done       <= 1'b0;
            err_len         <= 1'b0;
        end else begin
            in_mat_ena <= 1'b0;
            in_mat_wea <= 1'b0;
            in_mat_enb <= 1'b0;
            in_mat_web <= 1'b0;
            load_done  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= LOAD;
                        idx       <= '0;
                        finishing <= 1'b0;
                        s_tready  <= 1'b1;
                        err_len   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (finishing) begin
                        finishing <= 1'b0;
                        load_done <= 1'b1;
                        state     <= DONE;
                    end else if (accept) begin
                        if (s_tlast != at_last) begin
                            err_len <= 1'b1;
                        end
                        if (idx[0]) begin
                            in_mat_ena      <= 1'b1;
                            in_mat_wea      <= 1'b1;
                            in_mat_enb      <= 1'b1;
                            in_mat_web      <= 1'b1;
                            in_mat_wr_addra <= idx - ONE;
                            in_mat_dina     <= hold;
                            in_mat_wr_addrb <= idx;
                            in_mat_dinb     <= s_tdata;
                        end else if (final_beat) begin
                            // unpaired last word goes out on port A alone
                            in_mat_ena      <= 1'b1;
                            in_mat_wea      <= 1'b1;
                            in_mat_wr_addra <= idx;
                            in_mat_dina     <= s_tdata;
                        end else begin
                            hold <= s_tdata;
                        end
                        if (final_beat) begin
                            finishing <= 1'b1;
                            s_tready  <= 1'b0;
                        end else begin
                            idx <= idx + ONE;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    s_tready <= 1'b0;
                end
            endcase
        end
    end

endmodule
